// File: rtl/vram_pkg.sv
// Shared widths and FSM encoding for the VRAM line fetcher.
package vram_pkg;

  localparam int VRAM_WORD_AW = 15;
  localparam int VRAM_DATA_W  = 32;
  localparam int LINE_BUF_AW  = 8;
  localparam int IDX_W        = LINE_BUF_AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/vram_line_fetch_if.sv
// VRAM read port plus line-buffer write port, bundled for the fetcher.
interface vram_line_fetch_if
  import vram_pkg::*;
();

  logic [VRAM_WORD_AW-1:0] vram_addr;
  logic                    vram_strobe;
  logic                    vram_ack;
  logic [VRAM_DATA_W-1:0]  vram_rddata;
  logic                    buf_wr;
  logic [LINE_BUF_AW-1:0]  buf_addr;
  logic [VRAM_DATA_W-1:0]  buf_wrdata;

  modport master (
    output vram_addr,
    output vram_strobe,
    input  vram_ack,
    input  vram_rddata,
    output buf_wr,
    output buf_addr,
    output buf_wrdata
  );

  modport slave (
    input  vram_addr,
    input  vram_strobe,
    output vram_ack,
    output vram_rddata,
    input  buf_wr,
    input  buf_addr,
    input  buf_wrdata
  );

endinterface

// File: rtl/vram_line_fetch.sv
// Fetches a run of VRAM words into the line buffer, re-requesting lost grants.
// Define VRAM_FETCH_ABORT_EN to add the abort input.
module vram_line_fetch
  import vram_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VRAM_WORD_AW-1:0] start_addr,
  input  logic [7:0]              word_cnt,
  output logic                    busy,
  output logic                    done,
`ifdef VRAM_FETCH_ABORT_EN
  input  logic                    abort,
`endif
  vram_line_fetch_if.master       bus
);

  fetch_state_e state, state_nxt;

  logic [VRAM_WORD_AW-1:0] base;
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        exp_idx;
  logic [IDX_W-1:0]        fl_idx;
  logic                    fl_vld;
  logic                    abort_i;
  logic                    fin;
  logic                    strobe;
  logic                    wr;
  logic                    fl_is_exp;

`ifdef VRAM_FETCH_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign fin       = (exp_idx == cnt);
  assign fl_is_exp = fl_vld && (fl_idx == exp_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    strobe          = 1'b0;
    wr              = 1'b0;
    bus.vram_addr   = '0;
    bus.buf_addr    = '0;
    bus.buf_wrdata  = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        bus.vram_addr = base + VRAM_WORD_AW'(req_idx);
        if (abort_i) begin
          busy      = 1'b1;
          state_nxt = IDLE;
        end else if (fin) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          busy   = 1'b1;
          strobe = (req_idx < cnt);
          wr     = fl_vld & bus.vram_ack;
        end
        if (wr) begin
          bus.buf_addr   = fl_idx[LINE_BUF_AW-1:0];
          bus.buf_wrdata = bus.vram_rddata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.vram_strobe = strobe;
  assign bus.buf_wr      = wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base    <= '0;
      cnt     <= '0;
      req_idx <= '0;
      exp_idx <= '0;
      fl_idx  <= '0;
      fl_vld  <= 1'b0;
    end else begin
      fl_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base    <= start_addr;
            cnt     <= (word_cnt == 8'd0) ? 9'd256 : {1'b0, word_cnt};
            req_idx <= '0;
            exp_idx <= '0;
          end
        end
        FETCH: begin
          if (!abort_i && !fin) begin
            if (strobe) begin
              req_idx <= req_idx + 9'd1;
              fl_vld  <= 1'b1;
              fl_idx  <= req_idx;
            end
            if (fl_is_exp && bus.vram_ack)
              exp_idx <= exp_idx + 9'd1;
            // lost grant on the oldest missing word: rewind issue pointer
            if (fl_is_exp && !bus.vram_ack)
              req_idx <= exp_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_line_fetch.sv
// Scoreboard bench for vram_line_fetch with a grant-dropping VRAM model.
module tb_vram_line_fetch;
  import vram_pkg::*;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [7:0]  word_cnt = '0;
  logic        busy;
  logic        done;
  logic        abort = 1'b0;

  vram_line_fetch_if bus ();

  vram_line_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .done       (done),
`ifdef VRAM_FETCH_ABORT_EN
    .abort      (abort),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [14:0] saq[$];
  wr_t         wq[$];

  function automatic logic [31:0] mk_data(input logic [14:0] a);
    return {1'b1, a, 1'b0, ~a};
  endfunction

  // VRAM model: ack one cycle after a granted strobe; one grant can be dropped
  logic        pend = 1'b0;
  logic [14:0] paddr = '0;
  logic [14:0] drop_addr = '0;
  bit          drop_armed = 1'b0;

  initial begin
    bus.vram_ack    = 1'b0;
    bus.vram_rddata = '0;
  end

  always @(negedge clk) begin
    pend  = bus.vram_strobe;
    paddr = bus.vram_addr;
    if (pend && drop_armed && paddr == drop_addr) begin
      pend       = 1'b0;
      drop_armed = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.vram_ack    = pend;
    bus.vram_rddata = pend ? mk_data(paddr) : 32'hDEAD_BEEF;
  end

  // Scoreboard: every strobe and buffer write must match the next expectation
  always @(negedge clk) begin
    logic [14:0] ea;
    wr_t         ew;
    if (bus.vram_strobe === 1'b1) begin
      n_cmp++;
      if (saq.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected addr=%h required no strobe",
                 bus.vram_addr);
      end else begin
        ea = saq.pop_front();
        if (bus.vram_addr !== ea) begin
          n_err++;
          $display("FAIL vram_addr got=%h required=%h", bus.vram_addr, ea);
        end
      end
    end
    if (bus.buf_wr === 1'b1) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL buf_wr_unexpected addr=%h data=%h required no write",
                 bus.buf_addr, bus.buf_wrdata);
      end else begin
        ew = wq.pop_front();
        if (bus.buf_addr !== ew.a || bus.buf_wrdata !== ew.d) begin
          n_err++;
          $display("FAIL buf_write got=%h/%h required=%h/%h",
                   bus.buf_addr, bus.buf_wrdata, ew.a, ew.d);
        end
      end
    end
  end

  task automatic push_fetch(input logic [14:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [14:0] a;
      a = b + 15'(i);
      saq.push_back(a);
      wq.push_back('{a: 8'(i), d: mk_data(a)});
    end
  endtask

  task automatic do_start(input logic [14:0] a, input logic [7:0] n);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = a;
    word_cnt   = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int first_s,
                                output int done_c, output int ndone,
                                output logic busy_s, output logic busy_d);
    first_s = -1;
    done_c  = -1;
    ndone   = 0;
    busy_s  = 1'bx;
    busy_d  = 1'bx;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (first_s < 0 && bus.vram_strobe === 1'b1) begin
        first_s = c;
        busy_s  = busy;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c;
          busy_d = busy;
        end
      end
      if (done_c >= 0 && c >= done_c + 2) break;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bus.vram_strobe, bus.vram_addr, bus.buf_wr,
         bus.buf_addr, bus.buf_wrdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b strb=%b addr=%h wr=%b required all 0",
               busy, done, bus.vram_strobe, bus.vram_addr, bus.buf_wr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_fetch(input string nm, input int want_delta,
                             input int budget);
    int fs, dc, nd;
    logic bs, bd;
    run_until_done(budget, fs, dc, nd, bs, bd);
    n_cmp++;
    if (dc < 0 || fs < 0 || dc - fs != want_delta) begin
      n_err++;
      $display("FAIL %s_latency got=%0d required=%0d", nm, dc - fs, want_delta);
    end
    n_cmp++;
    if (nd != 1) begin
      n_err++;
      $display("FAIL %s_done_pulses got=%0d required=1", nm, nd);
    end
    n_cmp++;
    if (bs !== 1'b1 || bd !== 1'b0) begin
      n_err++;
      $display("FAIL %s_busy got=%b/%b required=1/0", nm, bs, bd);
    end
    n_cmp++;
    if (saq.size() != 0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover got=%0d/%0d required=0/0",
               nm, saq.size(), wq.size());
    end
  endtask

  task automatic test_basic();
    push_fetch(15'h0100, 4);
    do_start(15'h0100, 8'd4);
    check_fetch("basic", 5, 40);
  endtask

  task automatic test_retry();
    logic [14:0] b;
    b = 15'h0200;
    drop_addr  = b + 15'd1;
    drop_armed = 1'b1;
    saq.push_back(b);
    saq.push_back(b + 15'd1);
    saq.push_back(b + 15'd2);
    saq.push_back(b + 15'd1);
    saq.push_back(b + 15'd2);
    saq.push_back(b + 15'd3);
    wq.push_back('{a: 8'd0, d: mk_data(b)});
    wq.push_back('{a: 8'd2, d: mk_data(b + 15'd2)});
    wq.push_back('{a: 8'd1, d: mk_data(b + 15'd1)});
    wq.push_back('{a: 8'd2, d: mk_data(b + 15'd2)});
    wq.push_back('{a: 8'd3, d: mk_data(b + 15'd3)});
    do_start(b, 8'd4);
    check_fetch("retry", 7, 40);
    n_cmp++;
    if (drop_armed !== 1'b0) begin
      n_err++;
      $display("FAIL retry_drop_used got=%b required=0", drop_armed);
    end
  endtask

  task automatic test_wrap();
    push_fetch(15'h7FFE, 4);
    do_start(15'h7FFE, 8'd4);
    check_fetch("wrap", 5, 40);
  endtask

  task automatic test_full_line();
    push_fetch(15'h1234, 256);
    do_start(15'h1234, 8'd0);
    check_fetch("full256", 257, 300);
  endtask

  task automatic test_start_ignored();
    bit seen;
    push_fetch(15'h0300, 4);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 15'h0300;
    word_cnt   = 8'd4;
    @(posedge clk); #1;
    start_addr = 15'h0500;
    word_cnt   = 8'd2;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (seen !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored done/busy got=%b/%b required=1/0", seen, busy);
    end
    n_cmp++;
    if (saq.size() != 0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL start_ignored_leftover got=%0d/%0d required=0/0",
               saq.size(), wq.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [14:0] b;
    bit hit;
    int nd;
    b = 15'h0400;
    for (int i = 0; i <= 10; i++) saq.push_back(b + 15'(i));
    for (int i = 0; i < 10; i++)
      wq.push_back('{a: 8'(i), d: mk_data(b + 15'(i))});
    do_start(b, 8'd64);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (bus.vram_strobe === 1'b1 && bus.vram_addr == b + 15'd10) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL midrst_reach_idx10 got=0 required=1");
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bus.vram_strobe, bus.vram_addr, bus.buf_wr,
         bus.buf_addr, bus.buf_wrdata} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs got busy=%b strb=%b wr=%b required 0",
               busy, bus.vram_strobe, bus.buf_wr);
    end
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    n_cmp++;
    if (nd != 0 || saq.size() != 0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL midrst_discard done=%0d left=%0d/%0d required 0/0/0",
               nd, saq.size(), wq.size());
    end
    push_fetch(15'h0700, 4);
    do_start(15'h0700, 8'd4);
    check_fetch("after_rst", 5, 40);
  endtask

`ifdef VRAM_FETCH_ABORT_EN
  task automatic test_abort();
    logic [14:0] b;
    int nd;
    b = 15'h0040;
    for (int i = 0; i < 3; i++) saq.push_back(b + 15'(i));
    for (int i = 0; i < 2; i++)
      wq.push_back('{a: 8'(i), d: mk_data(b + 15'(i))});
    do_start(b, 8'd8);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.vram_strobe !== 1'b0 || bus.buf_wr !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_same_cycle strb/wr/done got=%b/%b/%b required=0/0/0",
               bus.vram_strobe, bus.buf_wr, done);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    n_cmp++;
    if (busy !== 1'b0 || nd != 0 || saq.size() != 0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL abort_idle busy=%b done=%0d left=%0d/%0d required 0/0/0/0",
               busy, nd, saq.size(), wq.size());
    end
    push_fetch(15'h0050, 2);
    @(posedge clk); #1;
    abort      = 1'b1;
    start      = 1'b1;
    start_addr = 15'h0050;
    word_cnt   = 8'd2;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check_fetch("abort_in_idle", 3, 40);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_wrap();
    test_full_line();
    test_start_ignored();
    test_mid_reset();
`ifdef VRAM_FETCH_ABORT_EN
    test_abort();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
